// File: rtl/regfile_wb.sv
// RV32I architectural register file with writeback bypass, a registered debug read port
// and a saturating count of committed register writes.
module regfile_wb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteW,
  input  logic [4:0]       RdW,
  input  logic [XLEN-1:0]  ResultW,
  input  logic [4:0]       A1D,
  input  logic [4:0]       A2D,
  output logic [XLEN-1:0]  RD1D,
  output logic [XLEN-1:0]  RD2D,
  input  logic [4:0]       DbgAddr,
  output logic [XLEN-1:0]  DbgData,
  output logic [CNT_W-1:0] WriteCount
);

  // x0 has no storage; entries 1..NREGS-1 only.
  logic [XLEN-1:0]  regs_q [1:NREGS-1];
  logic [XLEN-1:0]  regs_d [1:NREGS-1];
  logic [XLEN-1:0]  dbg_data_q, dbg_data_d;
  logic [CNT_W-1:0] write_count_q, write_count_d;

  logic             commit;
  logic [XLEN-1:0]  read_view [0:NREGS-1];

  assign commit = RegWriteW && (RdW != 5'd0) && !rst;

  // Write-first view shared by all read ports, so they agree on bypass and x0 handling.
  always_comb begin
    read_view[0] = '0;
    for (int i = 1; i < NREGS; i++) begin
      read_view[i] = regs_q[i];
      if (commit && (RdW == 5'(i))) begin
        read_view[i] = ResultW;
      end
    end
  end

  always_comb begin
    for (int i = 1; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (commit && (RdW == 5'(i))) begin
        regs_d[i] = ResultW;
      end
    end
  end

  always_comb begin
    dbg_data_d    = read_view[DbgAddr];
    write_count_d = write_count_q;
    if (commit && (write_count_q != {CNT_W{1'b1}})) begin
      write_count_d = write_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      dbg_data_q    <= '0;
      write_count_q <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      dbg_data_q    <= dbg_data_d;
      write_count_q <= write_count_d;
    end
  end

  assign RD1D       = read_view[A1D];
  assign RD2D       = read_view[A2D];
  assign DbgData    = dbg_data_q;
  assign WriteCount = write_count_q;

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Architectural integer register file for the RV32I pipeline and the receiving end of the writeback interface. It accepts one write per cycle from the WB stage (RegWriteW / RdW / ResultW) and serves two combinational read ports to the decode stage. A same-cycle write is bypassed to the readers, so decode never sees a stale value. A saturating counter of committed register writes is kept for bring-up and performance checks.

## Interface
- XLEN, riscv_pkg::XLEN (32): register data width.
- NREGS, 32: number of architectural registers; addresses are 5 bits.
- CNT_W, 32: width of the committed-write counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- RegWriteW  in  1  writeback write enable.
- RdW  in  5  writeback destination register.
- ResultW  in  XLEN  writeback data.
- A1D  in  5  decode read address, port 1 (rs1).
- A2D  in  5  decode read address, port 2 (rs2).
- RD1D  out  XLEN  read data, port 1, combinational.
- RD2D  out  XLEN  read data, port 2, combinational.
- DbgAddr  in  5  debug read address.
- DbgData  out  XLEN  debug read data, registered.
- WriteCount  out  CNT_W  number of committed non-x0 writes, saturating.

## Operation
- Storage is regs[1..31]. x0 has no storage: reads of address 0 return 0 on all ports.
- Commit condition: `commit = RegWriteW && (RdW != 0) && !rst`.
- On a commit, regs[RdW] <= ResultW at the rising edge.
- A write with RdW == 0 is discarded and not counted.
- Read port n (A = A1D or A2D):
  - If A == 0: output 0.
  - Else if commit && RdW == A: output ResultW (write-first bypass).
  - Else: output regs[A].
  - Both ports are fully independent and may read the same address.
- Debug port: DbgData <= the same value the read-port rule gives for DbgAddr, registered one cycle. Bypass applies, so a value being written in the same cycle is the one captured.
- WriteCount: increments by 1 on each commit and saturates at 2^CNT_W-1; it does not wrap.
- Reset, while rst is high at a clock edge:
  - All regs[1..31] clear to 0.
  - WriteCount clears to 0.
  - DbgData clears to 0.
  - Any concurrent write is dropped.

## Timing
- Write latency 1 cycle: data presented at edge k is readable through storage after edge k. In the cycle of edge k it is already visible through the bypass.
- Read latency for RD1D/RD2D: 0 cycles, combinational from A1D/A2D, RdW, RegWriteW and ResultW.
- Debug read latency: 1 cycle.
- Reset values: RD1D/RD2D = 0 for every address, since storage is zero and the bypass is disabled during rst. DbgData = 0. WriteCount = 0.
- Reset mid-operation: a write coincident with the reset edge is lost. The first write after rst deasserts lands normally.
- Back-to-back writes to the same Rd in consecutive cycles: the last one wins, and each one is counted.
- No combinational path from the read addresses to any registered state other than the DbgData capture.

## Test plan
- Reset then sweep: assert rst for 2 cycles after random fills, read all 32 addresses -> every RD1D/RD2D = 0, WriteCount = 0, DbgData = 0.
- x0 protection: write RdW=0, ResultW=0xDEADBEEF, RegWriteW=1 -> reading A1D=0 gives 0, WriteCount unchanged.
- Basic write/read: write x5=0x12345678, next cycle A1D=5, A2D=5 -> both ports 0x12345678, WriteCount=1.
- Same-cycle bypass: hold x7=0x11 in storage; in one cycle write x7=0x22 with A1D=7 and DbgAddr=7 -> RD1D=0x22 in that cycle, DbgData=0x22 one cycle later.
- Reset collision: write x9=0xAAAA in the cycle rst=1 -> after reset, x9 reads 0 and WriteCount=0. Writing x9=0xBBBB the next cycle then reads 0xBBBB with WriteCount=1.
- Counter saturation with CNT_W=4: perform 20 commits -> WriteCount reads 15 and stays at 15. Register contents still update on every commit.
